keccak_round_controller: RTL and testbench
==========================================

// Module: keccak_round_controller
// PURPOSE
//  Sequences one Keccak-f permutation over the iterative round datapath.
//  Accepts a start request, loads the state, steps the round index through
//  0..ROUNDS-1, and pulses the state-register enable once per round. Holds
//  completion until the consumer acknowledges it. Sits between the
//  sponge/host interface and the round datapath. Drives the round-constant
//  lookup index and the state load/enable strobes.
// PARAMETERS
//  W       8   lane width; only 8 (Keccak-f[200]) or 64 (Keccak-f[1600]) legal
//  LAT     1   cycles per round of the datapath (pipeline/DOM register stages), 1..7
//  ROUNDS  derived, not overridable: 18 if W==8, 24 if W==64
// PORTS
//  ClkxCI        in   1  clock, rising edge
//  RstxRI        in   1  synchronous reset, active-high
//  StartxSI      in   1  start request (valid)
//  ReadyxSO      out  1  controller can accept StartxSI
//  LoadxSO       out  1  load input state into state register (accept cycle)
//  RoundNrxDO    out  5  round index to round-constant lookup
//  StageNrxDO    out  3  stage index within current round, 0..LAT-1
//  StateEnxSO    out  1  state register captures round output this cycle
//  BusyxSO       out  1  permutation in progress
//  DonexSO       out  1  permutation complete, result valid (valid)
//  DoneAckxSI    in   1  consumer takes result (ready)
// BEHAVIOUR
//  - Interface: one clock ClkxCI; reset RstxRI is synchronous and active-high.
//  - Reset values: state IDLE, ReadyxSO=1, RoundNrxDO=0, StageNrxDO=0;
//    LoadxSO, StateEnxSO, BusyxSO and DonexSO all 0.
//  - FSM states: IDLE, ROUND, DONE. Binary encoded. All outputs are decoded
//    from registered state/counters; no input-to-output combinational path
//    except LoadxSO = StartxSI & ReadyxSO.
//  - IDLE: ReadyxSO=1.
//    - StartxSI=1 -> LoadxSO=1 in the same cycle; next state ROUND;
//      RoundNr=0, StageNr=0.
//    - StartxSI=0 -> stay in IDLE.
//  - ROUND: BusyxSO=1, ReadyxSO=0.
//    - Each cycle StageNr increments.
//    - When StageNr==LAT-1: StateEnxSO=1 and StageNr wraps to 0.
//      - If RoundNr==ROUNDS-1, next state DONE.
//      - Otherwise RoundNr increments.
//    - RoundNrxDO is stable for all LAT cycles of a round.
//  - DONE: DonexSO=1, ReadyxSO=0, BusyxSO=0.
//    - RoundNrxDO holds ROUNDS-1 and is not reset to 0 here.
//    - DoneAckxSI=1 -> IDLE; DonexSO drops on the next cycle.
//    - DonexSO is held indefinitely without an ack.
//  - Latency: if StartxSI is accepted at edge t, DonexSO rises at edge
//    t + ROUNDS*LAT. StateEnxSO is high in exactly ROUNDS cycles per run.
//  - Throughput: earliest restart is the cycle after the ack edge.
//    One idle cycle between runs is required.
//  - Boundary and illegal conditions:
//    - StartxSI in ROUND or DONE: ignored, no LoadxSO.
//    - DoneAckxSI outside DONE: ignored.
//    - StartxSI and DoneAckxSI both high in DONE: ack is taken, start is
//      dropped; the requester must hold StartxSI.
//    - RstxRI mid-run: IDLE on the next edge with reset values. No
//      StateEnxSO in that cycle. The partial result is discarded.
//  - Widths: RoundNr is 5 bits and never exceeds ROUNDS-1.
//    StageNr is 3 bits; when LAT==1 it is constant 0.
//  - Illegal W or LAT: elaboration error via generate-time check.
// STRUCTURE
//  - keccak_pkg: ROUNDS_F(W) function, the FSM state encoding localparams,
//    and the RoundNr width constant. The lane-size check is shared with the
//    round-constant lookup.
//  - One sub-module: keccak_round_counter. It holds the nested StageNr/RoundNr
//    counters with enable, clear, StateEn strobe and a last-round flag.
//  - The FSM stays in this file. keccak_roundconstant is instantiated by the
//    datapath top, fed from RoundNrxDO, not inside this block.
// TESTING
//  1. W=64, LAT=1; Start at cycle 0.
//     -> LoadxSO at cycle 0.
//     -> RoundNrxDO steps 0..23 over cycles 1..24.
//     -> StateEnxSO high in 24 consecutive cycles.
//     -> DonexSO at cycle 25.
//  2. W=8, LAT=3; Start at cycle 0.
//     -> StateEnxSO high on cycles 3, 6, ..., 54 (18 pulses).
//     -> Each RoundNr value is held 3 cycles.
//     -> DonexSO at cycle 55.
//  3. DONE held 10 cycles with DoneAckxSI=0, then ack.
//     -> DonexSO stays 1 throughout.
//     -> Start in the ack cycle is ignored.
//     -> Start the next cycle is accepted with RoundNr=0.
//  4. Reset pulse during round 7 (W=64, LAT=2).
//     -> Next cycle: IDLE, ReadyxSO=1, RoundNrxDO=0, no StateEnxSO.
//     -> A new Start completes a full 24-round run.
//  5. StartxSI held high continuously across two runs, with immediate ack.
//     -> Exactly one LoadxSO per run.
//     -> Runs are separated by exactly one IDLE cycle.
//  6. Random Start/Ack stimulus over 1000 runs, both W values, LAT 1..4.
//     -> Scoreboard checks ROUNDS StateEn pulses per run.
//     -> Latency check: ROUNDS*LAT.
//     -> Assertion: Busy, Done and Ready are one-hot.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants: round count per lane width, controller state
// encoding and the index widths used by the round sequencer.
package keccak_pkg;

  localparam int unsigned ROUND_NR_W = 5;
  localparam int unsigned STAGE_NR_W = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } ctrl_state_e;

  // Keccak-f[200] runs 18 rounds, Keccak-f[1600] runs 24.
  function automatic int unsigned rounds_f(input int unsigned w);
    return (w == 64) ? 24 : 18;
  endfunction

  // Only the two lane sizes with a matching round-constant table are legal.
  function automatic bit lane_width_ok(input int unsigned w);
    return (w == 8) || (w == 64);
  endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Nested stage/round counters for the iterative round datapath. The stage
// counter runs 0..LAT-1; each stage wrap strobes the state enable and
// advances the round index, which saturates at ROUNDS-1.
module keccak_round_counter
  import keccak_pkg::*;
#(
  parameter int unsigned LAT    = 1,
  parameter int unsigned ROUNDS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  output logic [ROUND_NR_W-1:0] round_nr,
  output logic [STAGE_NR_W-1:0] stage_nr,
  output logic                  state_en,
  output logic                  stage_last,
  output logic                  last_round
);

  logic [ROUND_NR_W-1:0] round_q, round_d;
  logic [STAGE_NR_W-1:0] stage_q, stage_d;

  assign stage_last = (stage_q == STAGE_NR_W'(LAT - 1));
  assign last_round = (round_q == ROUND_NR_W'(ROUNDS - 1));
  assign state_en   = enable & stage_last;
  assign round_nr   = round_q;
  assign stage_nr   = stage_q;

  // Next-state: clear wins, otherwise step the stage and carry into the round.
  always_comb begin
    round_d = round_q;
    stage_d = stage_q;
    if (clear) begin
      round_d = '0;
      stage_d = '0;
    end else if (enable) begin
      if (stage_last) begin
        stage_d = '0;
        // Round index holds at the final value so DONE can still present it.
        if (!last_round) begin
          round_d = round_q + 1'b1;
        end
      end else begin
        stage_d = stage_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
      stage_q <= '0;
    end else begin
      round_q <= round_d;
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/keccak_round_controller.sv
// Sequences one Keccak-f permutation: accepts a start, steps the round
// counters through ROUNDS rounds of LAT cycles each, then holds completion
// until the consumer acknowledges it.
module keccak_round_controller
  import keccak_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic                  ClkxCI,
  input  logic                  RstxRI,
  input  logic                  StartxSI,
  output logic                  ReadyxSO,
  output logic                  LoadxSO,
  output logic [ROUND_NR_W-1:0] RoundNrxDO,
  output logic [STAGE_NR_W-1:0] StageNrxDO,
  output logic                  StateEnxSO,
  output logic                  BusyxSO,
  output logic                  DonexSO,
  input  logic                  DoneAckxSI
);

  localparam int unsigned ROUNDS = rounds_f(W);

  if (!lane_width_ok(W)) begin : g_bad_lane
    $error("keccak_round_controller: W must be 8 or 64");
  end
  if ((LAT < 1) || (LAT > 7)) begin : g_bad_lat
    $error("keccak_round_controller: LAT must be within 1..7");
  end

  ctrl_state_e state_q, state_d;
  logic        cnt_clear;
  logic        cnt_en;
  logic        stage_last;
  logic        last_round;

  keccak_round_counter #(
    .LAT    (LAT),
    .ROUNDS (ROUNDS)
  ) u_round_counter (
    .clk        (ClkxCI),
    .rst        (RstxRI),
    .clear      (cnt_clear),
    .enable     (cnt_en),
    .round_nr   (RoundNrxDO),
    .stage_nr   (StageNrxDO),
    .state_en   (StateEnxSO),
    .stage_last (stage_last),
    .last_round (last_round)
  );

  // FSM next-state and decoded outputs; only LoadxSO sees an input directly.
  always_comb begin
    state_d   = state_q;
    ReadyxSO  = 1'b0;
    LoadxSO   = 1'b0;
    BusyxSO   = 1'b0;
    DonexSO   = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ReadyxSO = 1'b1;
        LoadxSO  = StartxSI;
        if (StartxSI) begin
          state_d   = StRound;
          cnt_clear = 1'b1;
        end
      end
      StRound: begin
        BusyxSO = 1'b1;
        cnt_en  = 1'b1;
        if (stage_last && last_round) begin
          state_d = StDone;
        end
      end
      StDone: begin
        DonexSO = 1'b1;
        // A start arriving with the ack is dropped: Ready is low here.
        if (DoneAckxSI) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_keccak_round_controller.sv
// Bench for keccak_round_controller: eight parameter sets share one stimulus
// stream; each is compared every cycle against an elapsed-time model and a
// per-run scoreboard, plus a table of directed sample points.
module tb_keccak_round_controller;

  localparam int NCFG = 8;
  localparam int X    = -1;

  function automatic int cfg_w(input int g);
    case (g)
      0: return 64;
      1: return 8;
      2: return 64;
      3: return 8;
      4: return 8;
      5: return 64;
      6: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_lat(input int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 2;
      3: return 1;
      4: return 2;
      5: return 3;
      6: return 4;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_rounds(input int g);
    return (cfg_w(g) == 64) ? 24 : 18;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ack;
  logic       ready    [NCFG];
  logic       load     [NCFG];
  logic       state_en [NCFG];
  logic       busy     [NCFG];
  logic       done     [NCFG];
  logic [4:0] round_nr [NCFG];
  logic [2:0] stage_nr [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    keccak_round_controller #(
      .W   (cfg_w(g)),
      .LAT (cfg_lat(g))
    ) u_dut (
      .ClkxCI     (clk),
      .RstxRI     (rst),
      .StartxSI   (start),
      .ReadyxSO   (ready[g]),
      .LoadxSO    (load[g]),
      .RoundNrxDO (round_nr[g]),
      .StageNrxDO (stage_nr[g]),
      .StateEnxSO (state_en[g]),
      .BusyxSO    (busy[g]),
      .DonexSO    (done[g]),
      .DoneAckxSI (ack)
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: phase 0 idle, 1 running (t cycles elapsed since load), 2 done.
  int m_ph [NCFG];
  int m_t  [NCFG];
  bit m_rk [NCFG];  // idle counters known to be zero (after reset)

  bit sb_act    [NCFG];
  int sb_pulses [NCFG];
  int sb_load   [NCFG];
  bit done_prev [NCFG];
  int last_load [NCFG];
  int n_loads   [NCFG];
  int runs = 0;
  bit count_runs = 0;
  bit dir_on = 0;
  bit gap_on = 0;

  typedef struct {
    int cyc; int cfg;
    int load; int ready; int busy; int done; int se; int rnd; int stg;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cfg%0d cycle %0d: got %0d expected %0d", name, g, cyc, act, exp);
    end
  endfunction

  function automatic bit all_ready();
    for (int g = 0; g < NCFG; g++) if (!ready[g]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_vec(input vec_t v);
    if (v.load  != X) chk("vec_load",  v.cfg, int'(load[v.cfg]),     v.load);
    if (v.ready != X) chk("vec_ready", v.cfg, int'(ready[v.cfg]),    v.ready);
    if (v.busy  != X) chk("vec_busy",  v.cfg, int'(busy[v.cfg]),     v.busy);
    if (v.done  != X) chk("vec_done",  v.cfg, int'(done[v.cfg]),     v.done);
    if (v.se    != X) chk("vec_se",    v.cfg, int'(state_en[v.cfg]), v.se);
    if (v.rnd   != X) chk("vec_round", v.cfg, int'(round_nr[v.cfg]), v.rnd);
    if (v.stg   != X) chk("vec_stage", v.cfg, int'(stage_nr[v.cfg]), v.stg);
  endtask

  task automatic check_all();
    for (int g = 0; g < NCFG; g++) begin
      int r, l;
      r = cfg_rounds(g);
      l = cfg_lat(g);
      chk("ready", g, int'(ready[g]), int'(m_ph[g] == 0));
      chk("busy",  g, int'(busy[g]),  int'(m_ph[g] == 1));
      chk("done",  g, int'(done[g]),  int'(m_ph[g] == 2));
      chk("load",  g, int'(load[g]),  int'((m_ph[g] == 0) && start));
      chk("state_en", g, int'(state_en[g]), int'((m_ph[g] == 1) && (m_t[g] % l == l - 1)));
      if (m_ph[g] == 1) begin
        chk("round_nr", g, int'(round_nr[g]), m_t[g] / l);
        chk("stage_nr", g, int'(stage_nr[g]), m_t[g] % l);
      end else if (m_ph[g] == 2) begin
        chk("round_hold", g, int'(round_nr[g]), r - 1);
      end else if (m_rk[g]) begin
        chk("idle_round", g, int'(round_nr[g]), 0);
        chk("idle_stage", g, int'(stage_nr[g]), 0);
      end
      chk("onehot", g, int'(ready[g]) + int'(busy[g]) + int'(done[g]), 1);
      // Per-run scoreboard, driven only by what the DUT shows.
      if (load[g] && !rst) begin
        sb_act[g]    = 1'b1;
        sb_pulses[g] = 0;
        sb_load[g]   = cyc;
        if (gap_on) begin
          if (last_load[g] >= 0) chk("restart_gap", g, cyc - last_load[g], r * l + 2);
          last_load[g] = cyc;
          n_loads[g]++;
        end
      end
      if (sb_act[g] && state_en[g]) sb_pulses[g]++;
      if (sb_act[g] && done[g] && !done_prev[g]) begin
        chk("run_pulses",  g, sb_pulses[g], r);
        chk("run_latency", g, cyc - sb_load[g], r * l + 1);
        sb_act[g] = 1'b0;
        if (count_runs) runs++;
      end
      if (rst) sb_act[g] = 1'b0;
      done_prev[g] = done[g];
    end
    if (dir_on) begin
      foreach (tbl[i]) if (tbl[i].cyc == cyc) check_vec(tbl[i]);
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < NCFG; g++) begin
      int r, l;
      r = cfg_rounds(g);
      l = cfg_lat(g);
      if (rst) begin
        m_ph[g] = 0;
        m_t[g]  = 0;
        m_rk[g] = 1'b1;
      end else begin
        case (m_ph[g])
          0: if (start) begin
            m_ph[g] = 1;
            m_t[g]  = 0;
          end
          1: begin
            m_t[g]++;
            if (m_t[g] == r * l) m_ph[g] = 2;
          end
          default: if (ack) begin
            m_ph[g] = 0;
            m_rk[g] = 1'b0;
          end
        endcase
      end
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge,
  // release the caller just after it to drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      m_ph[g] = 0; m_t[g] = 0; m_rk[g] = 1'b1;
      sb_act[g] = 1'b0; sb_pulses[g] = 0; sb_load[g] = 0; done_prev[g] = 1'b0;
      last_load[g] = -1; n_loads[g] = 0;
    end
    //                cyc  cfg load rdy busy done se  rnd stg
    tbl.push_back('{  0,   0,  1,   1,  0,   0,   0,  0,  0});
    tbl.push_back('{  1,   0,  0,   0,  1,   0,   1,  0,  0});
    tbl.push_back('{  2,   0,  0,   0,  1,   0,   1,  1,  0});
    tbl.push_back('{ 24,   0,  0,   0,  1,   0,   1, 23,  0});
    tbl.push_back('{ 25,   0,  0,   0,  0,   1,   0, 23,  X});
    tbl.push_back('{  1,   1,  0,   0,  1,   0,   0,  0,  0});
    tbl.push_back('{  3,   1,  X,   X,  1,   0,   1,  0,  2});
    tbl.push_back('{  4,   1,  X,   X,  1,   0,   0,  1,  0});
    tbl.push_back('{ 53,   1,  X,   X,  1,   0,   0, 17,  1});
    tbl.push_back('{ 54,   1,  X,   X,  1,   0,   1, 17,  2});
    tbl.push_back('{ 55,   1,  0,   0,  0,   1,   0, 17,  X});
    tbl.push_back('{ 18,   3,  X,   X,  1,   0,   1, 17,  0});
    tbl.push_back('{ 19,   3,  X,   X,  0,   1,   0, 17,  X});
    tbl.push_back('{ 96,   6,  X,   X,  1,   0,   1, 23,  3});
    tbl.push_back('{ 97,   6,  X,   X,  0,   1,   0, 23,  X});
    tbl.push_back('{107,   6,  X,   X,  X,   1,   X, 23,  X});
    tbl.push_back('{108,   0,  0,   0,  X,   1,   X,  X,  X});
    tbl.push_back('{108,   6,  0,   0,  X,   1,   X,  X,  X});
    tbl.push_back('{109,   0,  1,   1,  0,   0,   X,  X,  X});
    tbl.push_back('{109,   6,  1,   1,  0,   0,   X,  X,  X});
    tbl.push_back('{110,   0,  0,   0,  1,   0,   1,  0,  0});
    tbl.push_back('{110,   6,  0,   0,  1,   0,   0,  0,  0});

    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed runs from a common start; long DONE hold; ack+start collision.
    cyc = 0;
    dir_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 108) tick();
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dir_on = 1'b0;

    // Drain to idle, then reset in the middle of round 7 of the LAT=2 run.
    ack = 1'b1;
    n = 0;
    while (!all_ready() && n < 200) begin tick(); n++; end
    chk("drain_idle", 0, int'(all_ready()), 1);
    ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (round_nr[2] != 5'd7 && n < 40) begin tick(); n++; end
    chk("reach_round7", 2, int'(round_nr[2]), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", 2, int'(ready[2]), 1);
    chk("rst_round", 2, int'(round_nr[2]), 0);
    chk("rst_stage", 2, int'(stage_nr[2]), 0);
    chk("rst_state_en", 2, int'(state_en[2]), 0);
    chk("rst_busy", 2, int'(busy[2]), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done[2] && n < 100) begin tick(); n++; end
    chk("rerun_done", 2, int'(done[2]), 1);
    tick();

    // Start held high with immediate ack: back-to-back runs.
    gap_on = 1'b1;
    start = 1'b1; ack = 1'b1;
    repeat (260) tick();
    gap_on = 1'b0;
    start = 1'b0; ack = 1'b0;
    for (int g = 0; g < NCFG; g++) chk("two_loads", g, int'(n_loads[g] >= 2), 1);

    // Random start/ack with occasional reset.
    count_runs = 1'b1;
    n = 0;
    while (runs < 1000 && n < 40000) begin
      rst   = ($urandom_range(0, 399) == 0);
      start = $urandom_range(0, 1) != 0;
      ack   = ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    rst = 1'b0; start = 1'b0; ack = 1'b0;
    chk("random_runs", 0, int'(runs >= 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
